// File: rtl/alu_integrity_checker.sv
// -----------------------------------------------------------------------------
// alu_integrity_checker
//   Runtime golden-model checker for the 4-bit secure ALU. It samples each
//   operand/opcode presented to the ALU and recomputes the expected result and
//   flags. The expected values are delayed by the ALU latency and compared with
//   the ALU outputs. Mismatches are counted and fed to a windowed alarm FSM.
//   Every compared ALU response is also folded into a MISR signature.
//
// Parameters
//   DUT_LAT      ALU output latency in cycles (1..4)
//   ALARM_THRESH mismatches inside one window that raise the alarm (1..15)
//   WINDOW       compared samples per suspicion window (1..255)
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   en, A, B, op       ALU stimulus; sampled when en is high
//   dut_result/carry/zero/overflow   ALU response
//   clr_alarm          synchronous alarm clear
//   mismatch           one-cycle pulse per failing compare
//   alarm              sticky alarm
//   fail_vec, fail_op  {v,z,c,r} diff bits and opcode of the alarm-raising compare
//   err_count          failing compares, saturates at 255
//   chk_count          total compares, wraps
//   sig                MISR signature of the ALU responses
// -----------------------------------------------------------------------------
module alu_integrity_checker #(
   parameter int DUT_LAT      = 1,
   parameter int ALARM_THRESH = 2,
   parameter int WINDOW       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [3:0]  A,
   input  logic [3:0]  B,
   input  logic [1:0]  op,
   input  logic [3:0]  dut_result,
   input  logic        dut_carry,
   input  logic        dut_zero,
   input  logic        dut_overflow,
   input  logic        clr_alarm,
   output logic        mismatch,
   output logic        alarm,
   output logic [3:0]  fail_vec,
   output logic [1:0]  fail_op,
   output logic [7:0]  err_count,
   output logic [15:0] chk_count,
   output logic [15:0] sig
);

   localparam logic [3:0] THR_L = ALARM_THRESH[3:0];
   localparam logic [7:0] WIN_L = WINDOW[7:0];

   typedef enum logic [1:0] {
      ST_ARMED   = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_ALARM   = 2'd2
   } state_t;

   // Expected {result, carry, zero, overflow} for one ALU operation.
   function automatic logic [6:0] f_golden(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] o);
      logic [4:0] sum;
      logic [3:0] res;
      logic       cy;
      logic       ov;
      sum = 5'd0;
      res = 4'd0;
      cy  = 1'b0;
      ov  = 1'b0;
      case (o)
         2'b00: begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[3:0];
            cy  = sum[4];
            ov  = (a[3] == b[3]) && (res[3] != a[3]);
         end
         2'b01: begin
            // Two's-complement subtract; carry set means no borrow.
            sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
            res = sum[3:0];
            cy  = sum[4];
            ov  = (a[3] != b[3]) && (res[3] != a[3]);
         end
         2'b10:   res = a & b;
         2'b11:   res = a | b;
         default: res = 4'd0;
      endcase
      return {res, cy, (res == 4'd0), ov};
   endfunction

   logic [6:0]  w_exp_now;
   logic        r_pipe_vld  [DUT_LAT];
   logic [8:0]  r_pipe_data [DUT_LAT];   // {expected[6:0], op}
   logic [8:0]  w_tail;
   logic        w_cmp;
   logic [3:0]  w_diff;
   logic        w_fail;
   logic [15:0] w_sig_nxt;

   logic        r_mismatch;
   logic        r_alarm;
   logic [3:0]  r_fail_vec;
   logic [1:0]  r_fail_op;
   logic [7:0]  r_err_count;
   logic [15:0] r_chk_count;
   logic [15:0] r_sig;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_win_cnt;
   logic [7:0]  w_win_cnt_nxt;
   logic [3:0]  r_win_err;
   logic [3:0]  w_win_err_nxt;
   logic        w_enter_alarm;

   assign w_exp_now = f_golden(A, B, op);
   assign w_tail    = r_pipe_data[DUT_LAT-1];
   assign w_cmp     = r_pipe_vld[DUT_LAT-1];

   // Per-field diff bits, ordered {overflow, zero, carry, result}.
   assign w_diff = {(dut_overflow != w_tail[2]),
                    (dut_zero     != w_tail[3]),
                    (dut_carry    != w_tail[4]),
                    (dut_result   != w_tail[8:5])};
   assign w_fail = w_cmp && (w_diff != 4'd0);

   assign w_sig_nxt = {r_sig[14:0], r_sig[15] ^ r_sig[11] ^ r_sig[4]}
                      ^ {9'd0, dut_result, dut_carry, dut_zero, dut_overflow};

   // Expected-value delay line matching the ALU latency; reset flushes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DUT_LAT; i++) begin
            r_pipe_vld[i]  <= 1'b0;
            r_pipe_data[i] <= 9'd0;
         end
      end else begin
         r_pipe_vld[0]  <= en;
         r_pipe_data[0] <= {w_exp_now, op};
         for (int i = 1; i < DUT_LAT; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
         end
      end
   end

   // Compare bookkeeping: mismatch pulse, counters and MISR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mismatch  <= 1'b0;
         r_err_count <= 8'd0;
         r_chk_count <= 16'd0;
         r_sig       <= 16'hFFFF;
      end else begin
         r_mismatch <= w_fail;
         if (w_cmp) begin
            r_chk_count <= r_chk_count + 16'd1;
            r_sig       <= w_sig_nxt;
            if (w_fail && (r_err_count != 8'hFF)) begin
               r_err_count <= r_err_count + 8'd1;
            end
         end
      end
   end

   // Alarm FSM next state; a clear on the same edge as a compare wins and the
   // compare is kept out of the window.
   always_comb begin
      w_state_nxt   = r_state;
      w_win_cnt_nxt = r_win_cnt;
      w_win_err_nxt = r_win_err;
      w_enter_alarm = 1'b0;
      if (clr_alarm) begin
         w_state_nxt   = ST_ARMED;
         w_win_cnt_nxt = 8'd0;
         w_win_err_nxt = 4'd0;
      end else if (w_cmp) begin
         case (r_state)
            ST_ARMED: begin
               if (w_fail) begin
                  if (THR_L == 4'd1) begin
                     w_state_nxt   = ST_ALARM;
                     w_enter_alarm = 1'b1;
                  end else begin
                     w_state_nxt   = ST_SUSPECT;
                     w_win_cnt_nxt = 8'd1;
                     w_win_err_nxt = 4'd1;
                  end
               end else begin
                  w_state_nxt = ST_ARMED;
               end
            end
            ST_SUSPECT: begin
               w_win_cnt_nxt = r_win_cnt + 8'd1;
               w_win_err_nxt = r_win_err + {3'd0, w_fail};
               if (w_fail && (w_win_err_nxt >= THR_L)) begin
                  w_state_nxt   = ST_ALARM;
                  w_enter_alarm = 1'b1;
                  w_win_cnt_nxt = 8'd0;
                  w_win_err_nxt = 4'd0;
               end else if (w_win_cnt_nxt >= WIN_L) begin
                  w_state_nxt   = ST_ARMED;
                  w_win_cnt_nxt = 8'd0;
                  w_win_err_nxt = 4'd0;
               end else begin
                  w_state_nxt = ST_SUSPECT;
               end
            end
            ST_ALARM: w_state_nxt = ST_ALARM;
            default: begin
               w_state_nxt   = ST_ARMED;
               w_win_cnt_nxt = 8'd0;
               w_win_err_nxt = 4'd0;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Alarm FSM state register, sticky alarm and failure capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_ARMED;
         r_win_cnt  <= 8'd0;
         r_win_err  <= 4'd0;
         r_alarm    <= 1'b0;
         r_fail_vec <= 4'd0;
         r_fail_op  <= 2'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_win_cnt <= w_win_cnt_nxt;
         r_win_err <= w_win_err_nxt;
         r_alarm   <= (w_state_nxt == ST_ALARM);
         if (w_enter_alarm) begin
            r_fail_vec <= w_diff;
            r_fail_op  <= w_tail[1:0];
         end
      end
   end

   assign mismatch  = r_mismatch;
   assign alarm     = r_alarm;
   assign fail_vec  = r_fail_vec;
   assign fail_op   = r_fail_op;
   assign err_count = r_err_count;
   assign chk_count = r_chk_count;
   assign sig       = r_sig;

endmodule
